packing_ctrl: RTL and testbench

Sequencing controller for the length-packing stage of the compressor. It accepts one compressed code length per cycle and tracks the fill level of the 128-bit output packing register. It generates the store, shift, push, overflow, output and fill control flags that the length-packing pipeline register carries to the bit packer. It also runs the end-of-stream pad-and-flush sequence and holds off the upstream encoder while a full 128-bit word waits for the consumer.

---
 rtl/packing_pkg.sv | 17 +
 rtl/pack_stats_cnt.sv | 28 ++
 rtl/packing_ctrl.sv | 147 ++++++++++++++
 tb/tb_packing_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/packing_pkg.sv
// Shared types and defaults for the length-packing controller.
package packing_pkg;

  localparam int PACK_OUT_WIDTH = 128;
  localparam int PACK_MAX_LEN   = 64;

  typedef logic [7:0] fill_cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_EMIT   = 3'd2,
    ST_PAD    = 3'd3,
    ST_FINAL  = 3'd4
  } pack_state_e;

endpackage

// File: rtl/pack_stats_cnt.sv
// Saturating word and bit counters for the packing controller statistics.
module pack_stats_cnt (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        word_inc,
  input  logic        bit_inc,
  input  logic [6:0]  bit_len,
  output logic [31:0] o_word_count,
  output logic [31:0] o_bit_count
);

  logic [32:0] bit_sum;

  assign bit_sum = {1'b0, o_bit_count} + {26'd0, bit_len};

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_word_count <= '0;
      o_bit_count  <= '0;
    end else begin
      if (word_inc && (o_word_count != '1))
        o_word_count <= o_word_count + 32'd1;
      if (bit_inc)
        o_bit_count <= bit_sum[32] ? '1 : bit_sum[31:0];
    end
  end

endmodule

// File: rtl/packing_ctrl.sv
// Length-packing sequencer: fill accumulator, word emit handshake and end-of-stream pad/flush.
// Optional statistics counters are built when PACK_STATS_EN is defined.
//
// state  | meaning
// IDLE   | no stream in progress, waiting for the first code
// ACCEPT | taking one code length per cycle into the packing register
// EMIT   | full word pending, upstream held off until the consumer takes it
// PAD    | pad the partial last word up to OUT_WIDTH
// FINAL  | last word handed off, pulse finish and return to IDLE
module packing_ctrl
  import packing_pkg::*;
#(
  parameter int OUT_WIDTH = PACK_OUT_WIDTH,
  parameter int MAX_LEN   = PACK_MAX_LEN
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [6:0] i_total_length,
  input  logic       i_finish,
  output logic       o_store_flag,
  output logic [7:0] o_shift_amount,
  output logic       o_push_flag,
  output logic       o_output_flag,
  output logic       o_stop_flag,
  output logic       o_fill_flag,
  output logic       o_fill_ctrl,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic       o_finish_final,
  output fill_cnt_t  o_fill_count
`ifdef PACK_STATS_EN
  ,
  output logic [31:0] o_word_count,
  output logic [31:0] o_bit_count
`endif
);

  localparam logic [8:0] OUT_W9 = 9'(OUT_WIDTH);

  pack_state_e state, state_nxt;
  fill_cnt_t   c_nxt;
  logic        fin_pend;
  logic        fin_now;
  logic        accept;
  logic        len_nz;
  logic [8:0]  sum;
  logic        push;
  logic        boundary;
  logic        spill;

  assign accept  = i_valid && o_ready;
  assign len_nz  = (i_total_length != 7'd0);
  assign fin_now = fin_pend || i_finish;
  assign sum     = {1'b0, o_fill_count} + {2'b00, i_total_length};

  always_comb begin
    state_nxt = state;
    c_nxt     = o_fill_count;
    push      = 1'b0;
    boundary  = 1'b0;
    spill     = 1'b0;
    case (state)
      ST_IDLE, ST_ACCEPT: begin
        if (accept) begin
          state_nxt = ST_ACCEPT;
          if (len_nz) begin
            if (sum < OUT_W9) begin
              c_nxt = sum[7:0];
              push  = 1'b1;
            end else begin
              c_nxt     = fill_cnt_t'(sum - OUT_W9);
              boundary  = 1'b1;
              spill     = (sum != OUT_W9);
              state_nxt = ST_EMIT;
            end
          end
        end
        // A boundary crossing always emits first; the pad decision waits for the handshake.
        if (!boundary && fin_now)
          state_nxt = (c_nxt != '0) ? ST_PAD : ST_FINAL;
      end
      ST_EMIT: begin
        if (i_out_ready) begin
          if (fin_now) state_nxt = (o_fill_count != '0) ? ST_PAD : ST_FINAL;
          else         state_nxt = ST_ACCEPT;
        end
      end
      ST_PAD: begin
        state_nxt = ST_EMIT;
        c_nxt     = '0;
      end
      ST_FINAL: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state          <= ST_IDLE;
      fin_pend       <= 1'b0;
      o_fill_count   <= '0;
      o_ready        <= 1'b0;
      o_store_flag   <= 1'b0;
      o_shift_amount <= '0;
      o_push_flag    <= 1'b0;
      o_output_flag  <= 1'b0;
      o_stop_flag    <= 1'b0;
      o_fill_flag    <= 1'b0;
      o_fill_ctrl    <= 1'b0;
      o_out_valid    <= 1'b0;
      o_finish_final <= 1'b0;
    end else begin
      state          <= state_nxt;
      o_fill_count   <= c_nxt;
      fin_pend       <= (state == ST_FINAL) ? 1'b0 : fin_now;
      o_ready        <= (state_nxt == ST_IDLE) || (state_nxt == ST_ACCEPT);
      o_store_flag   <= accept;
      o_push_flag    <= push;
      o_stop_flag    <= spill;
      o_output_flag  <= boundary || (state == ST_PAD);
      o_fill_ctrl    <= (state == ST_PAD);
      o_fill_flag    <= (state == ST_PAD) || ((state == ST_EMIT) && o_fill_flag && !i_out_ready);
      o_out_valid    <= (state_nxt == ST_EMIT);
      o_finish_final <= (state_nxt == ST_FINAL);
      if (accept || (state == ST_PAD))
        o_shift_amount <= o_fill_count;
    end
  end

`ifdef PACK_STATS_EN
  pack_stats_cnt u_stats (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .word_inc     ((state == ST_EMIT) && i_out_ready),
    .bit_inc      (accept),
    .bit_len      (i_total_length),
    .o_word_count (o_word_count),
    .o_bit_count  (o_bit_count)
  );
`endif

  a_len_legal: assert property (@(posedge i_clk) disable iff (!i_reset)
    accept |-> (int'(i_total_length) <= MAX_LEN));

endmodule

// File: tb/tb_packing_ctrl.sv
// Directed bench for packing_ctrl: accumulate, boundary, stall, pad/flush and reset scenarios.
module tb_packing_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid = 1'b0;
  logic       ready;
  logic [6:0] len = '0;
  logic       finish = 1'b0;
  logic       store, push, outf, stop, fillf, fillc, ovalid, ffinal;
  logic [7:0] shift, count;
  logic       out_ready = 1'b1;
`ifdef PACK_STATS_EN
  logic [31:0] word_count, bit_count;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  packing_ctrl dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_valid        (valid),
    .o_ready        (ready),
    .i_total_length (len),
    .i_finish       (finish),
    .o_store_flag   (store),
    .o_shift_amount (shift),
    .o_push_flag    (push),
    .o_output_flag  (outf),
    .o_stop_flag    (stop),
    .o_fill_flag    (fillf),
    .o_fill_ctrl    (fillc),
    .o_out_valid    (ovalid),
    .i_out_ready    (out_ready),
    .o_finish_final (ffinal),
    .o_fill_count   (count)
`ifdef PACK_STATS_EN
    ,
    .o_word_count   (word_count),
    .o_bit_count    (bit_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_code(input logic [6:0] l, input logic fin);
    valid  = 1'b1;
    len    = l;
    finish = fin;
    tick();
    valid  = 1'b0;
    finish = 1'b0;
  endtask

  // {ready, store, push, output, stop, fill_flag, fill_ctrl, out_valid, finish_final}
  function automatic logic [8:0] flags();
    return {ready, store, push, outf, stop, fillf, fillc, ovalid, ffinal};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    #3;
    total_cnt++;
    if ({flags(), shift, count} !== 25'd0) $display("FAIL reset_outputs: got %b expected all zero", {flags(), shift, count});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    tick();
    total_cnt++;
    if (flags() !== 9'b1_0000_0000 || count !== 8'd0) $display("FAIL reset_release: flags %b count %0d expected 100000000 / 0", flags(), count);
    else pass_cnt++;
  endtask

  task automatic test_push();
    logic [7:0] exp_c = 8'd0;
    for (int i = 0; i < 3; i++) begin
      drive_code(7'd40, 1'b0);
      total_cnt++;
      if ({store, push, outf, stop} !== 4'b1100 || shift !== exp_c || count !== exp_c + 8'd40)
        $display("FAIL push_%0d: flags %b shift %0d count %0d expected 1100 / %0d / %0d", i, {store, push, outf, stop}, shift, count, exp_c, exp_c + 8'd40);
      else pass_cnt++;
      exp_c = exp_c + 8'd40;
    end
  endtask

  task automatic test_boundary();
    drive_code(7'd8, 1'b0);
    total_cnt++;
    if (flags() !== 9'b0_1010_0010 || shift !== 8'd120 || count !== 8'd0)
      $display("FAIL exact_boundary: flags %b shift %0d count %0d expected 010100010 / 120 / 0", flags(), shift, count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (flags() !== 9'b1_0000_0000) $display("FAIL boundary_emit_one_cycle: flags %b expected 100000000", flags());
    else pass_cnt++;
  endtask

  task automatic test_stop_stall();
    drive_code(7'd64, 1'b0);
    drive_code(7'd36, 1'b0);
    total_cnt++;
    if (count !== 8'd100 || push !== 1'b1) $display("FAIL fill_to_100: count %0d push %b expected 100 / 1", count, push);
    else pass_cnt++;
    out_ready = 1'b0;
    drive_code(7'd64, 1'b0);
    total_cnt++;
    if ({store, push, outf, stop} !== 4'b1011 || shift !== 8'd100 || count !== 8'd36 || ovalid !== 1'b1)
      $display("FAIL straddle: flags %b shift %0d count %0d ovalid %b expected 1011 / 100 / 36 / 1", {store, push, outf, stop}, shift, count, ovalid);
    else pass_cnt++;
    valid = 1'b1;
    len   = 7'd10;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if (ready !== 1'b0 || ovalid !== 1'b1 || store !== 1'b0 || count !== 8'd36)
        $display("FAIL stall_%0d: ready %b ovalid %b store %b count %0d expected 0 / 1 / 0 / 36", i, ready, ovalid, store, count);
      else pass_cnt++;
    end
    valid     = 1'b0;
    out_ready = 1'b1;
    tick();
    total_cnt++;
    if (ready !== 1'b1 || ovalid !== 1'b0 || count !== 8'd36)
      $display("FAIL stall_release: ready %b ovalid %b count %0d expected 1 / 0 / 36", ready, ovalid, count);
    else pass_cnt++;
  endtask

  task automatic test_zero_len();
    drive_code(7'd0, 1'b0);
    total_cnt++;
    if ({store, push, outf, stop} !== 4'b1000 || count !== 8'd36)
      $display("FAIL zero_len: flags %b count %0d expected 1000 / 36", {store, push, outf, stop}, count);
    else pass_cnt++;
  endtask

  task automatic test_pad();
    drive_code(7'd14, 1'b0);
    total_cnt++;
    if (count !== 8'd50) $display("FAIL fill_to_50: count %0d expected 50", count);
    else pass_cnt++;
    finish    = 1'b1;
    tick();
    finish    = 1'b0;
    out_ready = 1'b0;
    total_cnt++;
    if (flags() !== 9'b0_0000_0000) $display("FAIL pad_entry: flags %b expected 000000000", flags());
    else pass_cnt++;
    tick();
    total_cnt++;
    if (flags() !== 9'b0_0010_1110 || shift !== 8'd50 || count !== 8'd0)
      $display("FAIL pad_strobe: flags %b shift %0d count %0d expected 000101110 / 50 / 0", flags(), shift, count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (flags() !== 9'b0_0000_1010) $display("FAIL pad_emit_hold: flags %b expected 000001010", flags());
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
    total_cnt++;
    if (flags() !== 9'b0_0000_0001) $display("FAIL pad_final: flags %b expected 000000001", flags());
    else pass_cnt++;
    tick();
    total_cnt++;
    if (flags() !== 9'b1_0000_0000) $display("FAIL pad_idle: flags %b expected 100000000", flags());
    else pass_cnt++;
  endtask

  task automatic test_finish_zero();
    drive_code(7'd64, 1'b0);
    drive_code(7'd56, 1'b0);
    drive_code(7'd8, 1'b1);
    total_cnt++;
    if (outf !== 1'b1 || stop !== 1'b0 || ovalid !== 1'b1 || count !== 8'd0)
      $display("FAIL fin_zero_emit: out %b stop %b ovalid %b count %0d expected 1 / 0 / 1 / 0", outf, stop, ovalid, count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (flags() !== 9'b0_0000_0001) $display("FAIL fin_zero_final: flags %b expected 000000001", flags());
    else pass_cnt++;
    tick();
    total_cnt++;
    if (flags() !== 9'b1_0000_0000) $display("FAIL fin_zero_idle: flags %b expected 100000000", flags());
    else pass_cnt++;
  endtask

  task automatic test_finish_spill();
    drive_code(7'd64, 1'b0);
    drive_code(7'd36, 1'b0);
    drive_code(7'd64, 1'b1);
    total_cnt++;
    if (stop !== 1'b1 || ovalid !== 1'b1 || count !== 8'd36)
      $display("FAIL fin_spill_emit: stop %b ovalid %b count %0d expected 1 / 1 / 36", stop, ovalid, count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (flags() !== 9'b0_0000_0000) $display("FAIL fin_spill_pad: flags %b expected 000000000", flags());
    else pass_cnt++;
    tick();
    total_cnt++;
    if (flags() !== 9'b0_0010_1110 || shift !== 8'd36)
      $display("FAIL fin_spill_strobe: flags %b shift %0d expected 000101110 / 36", flags(), shift);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (flags() !== 9'b0_0000_0001) $display("FAIL fin_spill_final: flags %b expected 000000001", flags());
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    drive_code(7'd64, 1'b0);
    out_ready = 1'b0;
    drive_code(7'd64, 1'b0);
    total_cnt++;
    if (ovalid !== 1'b1) $display("FAIL mid_emit_setup: ovalid %b expected 1", ovalid);
    else pass_cnt++;
    #3;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({flags(), shift, count} !== 25'd0) $display("FAIL reset_async: got %b expected all zero", {flags(), shift, count});
    else pass_cnt++;
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    total_cnt++;
    if (flags() !== 9'b1_0000_0000 || count !== 8'd0)
      $display("FAIL reset_recover: flags %b count %0d expected 100000000 / 0", flags(), count);
    else pass_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_push();
    test_boundary();
    test_stop_stall();
    test_zero_len();
    test_pad();
    test_finish_zero();
    test_finish_spill();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
